i2c_rx_ctrl: RTL and testbench

//  I2C slave receive controller: frame FSM that drives the serial-to-parallel receive shift register.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_rx_ctrl_flex_counter.sv | 29 ++
 rtl/i2c_rx_ctrl.sv | 130 +++++++++++++
 tb/tb_i2c_rx_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive path.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam logic [ADDR_W-1:0] GENERAL_CALL_ADDR = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_rx_state_t;

endpackage

// File: rtl/i2c_rx_ctrl_flex_counter.sv
// Parameterised up-counter with synchronous clear and a terminal-count flag.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) count_out <= NUM_CNT_BITS'(1);
      else                           count_out <= count_out + 1'b1;
    end
  end

  always_comb begin
    rollover_flag = (count_out == rollover_val);
  end

endmodule

// File: rtl/i2c_rx_ctrl.sv
// I2C slave receive controller: address match, ACK/NACK generation, byte hand-off.
// Optional feature: define I2C_GENERAL_CALL_EN to also accept the general-call address.
module i2c_rx_ctrl
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h71,
  parameter int unsigned       DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_found,
  input  logic              stop_found,
  input  logic              rising_edge_found,
  input  logic              falling_edge_found,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              byte_ready,
  output logic              rx_enable,
  output logic              sda_drive_low,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_out,
  output logic              addr_matched,
  output logic              overrun,
  output logic              busy
`ifdef I2C_GENERAL_CALL_EN
  , output logic            general_call
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  i2c_rx_state_t state_q, state_d;
  logic [CNT_W-1:0] bit_cnt;
  logic bit_done, cnt_clear, cnt_en;
  logic in_rx, in_ack, bus_evt;
  logic capture, addr_cap, data_cap, addr_hit, addr_take, accept, ack_done;
  logic nack_q, ack_rise_q;
`ifdef I2C_GENERAL_CALL_EN
  logic gc_hit;
`endif

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_bit_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (CNT_W'(DATA_W)),
    .count_out    (bit_cnt),
    .rollover_flag(bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_rx     = (state_q == ST_ADDR) || (state_q == ST_DATA);
    in_ack    = (state_q == ST_ADDR_ACK) || (state_q == ST_DATA_ACK);
    bus_evt   = start_found || stop_found;
    capture   = in_rx && bit_done && falling_edge_found && !bus_evt;
    addr_cap  = capture && (state_q == ST_ADDR);
    data_cap  = capture && (state_q == ST_DATA);
    addr_hit  = (rx_data[DATA_W-1 -: ADDR_W] == SLAVE_ADDR) && !rx_data[0];
`ifdef I2C_GENERAL_CALL_EN
    gc_hit    = (rx_data[DATA_W-1 -: ADDR_W] == GENERAL_CALL_ADDR) && !rx_data[0];
    addr_take = addr_cap && (addr_hit || gc_hit);
`else
    addr_take = addr_cap && addr_hit;
`endif
    accept    = !byte_valid || byte_ready;
    ack_done  = in_ack && ack_rise_q && falling_edge_found;
    cnt_en    = in_rx && rising_edge_found && !bit_done;
    cnt_clear = bus_evt || capture || !in_rx;

    case (state_q)
      ST_ADDR:     if (addr_cap) state_d = addr_take ? ST_ADDR_ACK : ST_IGNORE;
      ST_ADDR_ACK: if (ack_done) state_d = ST_DATA;
      ST_DATA:     if (data_cap) state_d = ST_DATA_ACK;
      ST_DATA_ACK: if (ack_done) state_d = ST_DATA;
      default:     state_d = state_q;
    endcase

    if (stop_found)       state_d = ST_IDLE;
    else if (start_found) state_d = ST_ADDR;

    rx_enable     = in_rx;
    sda_drive_low = (state_q == ST_ADDR_ACK) || ((state_q == ST_DATA_ACK) && !nack_q);
    busy          = (state_q != ST_IDLE);
  end

  // A new byte landing in the same cycle the consumer drains the old one takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_valid   <= 1'b0;
      byte_out     <= '0;
      overrun      <= 1'b0;
      addr_matched <= 1'b0;
      nack_q       <= 1'b0;
      ack_rise_q   <= 1'b0;
    end else begin
      if (bus_evt)        addr_matched <= 1'b0;
      else if (addr_take) addr_matched <= 1'b1;

      if (start_found)              overrun <= 1'b0;
      else if (data_cap && !accept) overrun <= 1'b1;

      if (data_cap && accept) begin
        byte_valid <= 1'b1;
        byte_out   <= rx_data;
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end

      if (data_cap) nack_q <= !accept;

      if (in_ack) ack_rise_q <= ack_rise_q || rising_edge_found;
      else        ack_rise_q <= 1'b0;
    end
  end

`ifdef I2C_GENERAL_CALL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      general_call <= 1'b0;
    else if (bus_evt)             general_call <= 1'b0;
    else if (addr_cap && gc_hit)  general_call <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_i2c_rx_ctrl.sv
// Self-checking bench for i2c_rx_ctrl: address table plus overrun/STOP/repeated-START sequences.
module tb_i2c_rx_ctrl;

`ifdef I2C_GENERAL_CALL_EN
  localparam logic GC_EXP = 1'b1;
`else
  localparam logic GC_EXP = 1'b0;
`endif

  localparam int unsigned P_START = 0, P_STOP = 1, P_RISE = 2, P_FALL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_found, stop_found, rising_edge_found, falling_edge_found;
  logic [7:0] rx_data;
  logic       byte_ready;
  logic       rx_enable, sda_drive_low, byte_valid, addr_matched, overrun, busy;
  logic [7:0] byte_out;
`ifdef I2C_GENERAL_CALL_EN
  logic       general_call;
`endif

  i2c_rx_ctrl #(.SLAVE_ADDR(7'h71), .DATA_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_found       (start_found),
    .stop_found        (stop_found),
    .rising_edge_found (rising_edge_found),
    .falling_edge_found(falling_edge_found),
    .rx_data           (rx_data),
    .byte_ready        (byte_ready),
    .rx_enable         (rx_enable),
    .sda_drive_low     (sda_drive_low),
    .byte_valid        (byte_valid),
    .byte_out          (byte_out),
    .addr_matched      (addr_matched),
    .overrun           (overrun),
    .busy              (busy)
`ifdef I2C_GENERAL_CALL_EN
    , .general_call    (general_call)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every accepted hand-off must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_byte: got %0h expected none", byte_out);
      end else begin
        check("scoreboard_byte", {24'h0, byte_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic pulse(input int unsigned which);
    case (which)
      P_START: start_found        = 1'b1;
      P_STOP:  stop_found         = 1'b1;
      P_RISE:  rising_edge_found  = 1'b1;
      default: falling_edge_found = 1'b1;
    endcase
    tick();
    start_found = 1'b0; stop_found = 1'b0;
    rising_edge_found = 1'b0; falling_edge_found = 1'b0;
  endtask

  task automatic send_bits(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      pulse(P_RISE); idle(2);
      pulse(P_FALL); idle(2);
    end
  endtask

  // Eight SCL clocks then the ACK clock; ack sampled after capture, after 9th rise, after 9th fall.
  task automatic send_byte(input logic [7:0] b, input logic rdy_cap,
                           output logic ack_a, output logic ack_b, output logic ack_c,
                           output logic rxen);
    rx_data = b;
    send_bits(7);
    pulse(P_RISE); idle(2);
    if (rdy_cap) byte_ready = 1'b1;
    pulse(P_FALL);
    if (rdy_cap) byte_ready = 1'b0;
    ack_a = sda_drive_low;
    rxen  = rx_enable;
    idle(2);
    pulse(P_RISE);
    ack_b = sda_drive_low;
    idle(2);
    pulse(P_FALL);
    ack_c = sda_drive_low;
    idle(2);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_ack;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic a, b, c, re;

    vecs[0] = '{addr: 8'hE2, data: 8'h5A, exp_ack: 1'b1};
    vecs[1] = '{addr: 8'hE4, data: 8'hA5, exp_ack: 1'b0};
    vecs[2] = '{addr: 8'hE3, data: 8'h12, exp_ack: 1'b0};
    vecs[3] = '{addr: 8'hE0, data: 8'h34, exp_ack: 1'b0};
    vecs[4] = '{addr: 8'h00, data: 8'h77, exp_ack: GC_EXP};
    vecs[5] = '{addr: 8'hE2, data: 8'hC3, exp_ack: 1'b1};

    rst = 1'b1;
    start_found = 1'b0; stop_found = 1'b0;
    rising_edge_found = 1'b0; falling_edge_found = 1'b0;
    rx_data = 8'h00; byte_ready = 1'b0;
    idle(2);
    check("rst_rx_enable", rx_enable, 0);
    check("rst_sda", sda_drive_low, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_addr_matched", addr_matched, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    idle(2);

    // Table: one address + one data byte per transaction, consumer always ready.
    byte_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulse(P_START); idle(2);
      check("tbl_busy", busy, 1);
      check("tbl_rx_enable_addr", rx_enable, 1);
      send_byte(vecs[i].addr, 1'b0, a, b, c, re);
      check("tbl_addr_ack", a, vecs[i].exp_ack);
      check("tbl_addr_ack_9th", b, vecs[i].exp_ack);
      check("tbl_addr_ack_end", c, 0);
      check("tbl_rx_enable_after8", re, 0);
      check("tbl_addr_matched", addr_matched, vecs[i].exp_ack);
`ifdef I2C_GENERAL_CALL_EN
      check("tbl_general_call", general_call, vecs[i].addr == 8'h00);
`endif
      if (vecs[i].exp_ack) exp_q.push_back(vecs[i].data);
      send_byte(vecs[i].data, 1'b0, a, b, c, re);
      check("tbl_data_ack", a, vecs[i].exp_ack);
      check("tbl_data_ack_9th", b, vecs[i].exp_ack);
      check("tbl_data_ack_end", c, 0);
      check("tbl_valid_one_cycle", byte_valid, 0);
      if (vecs[i].exp_ack) check("tbl_byte_out", byte_out, vecs[i].data);
      pulse(P_STOP);
      check("tbl_stop_busy", busy, 0);
      check("tbl_stop_matched", addr_matched, 0);
      idle(2);
    end

    // Overrun: consumer stalled, second byte is NACKed and the first one is kept.
    byte_ready = 1'b0;
    pulse(P_START); idle(2);
    send_byte(8'hE2, 1'b0, a, b, c, re);
    check("ovr_addr_ack", a, 1);
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b0, a, b, c, re);
    check("ovr_first_ack", a, 1);
    check("ovr_first_valid", byte_valid, 1);
    send_byte(8'h22, 1'b0, a, b, c, re);
    check("ovr_second_nack", a, 0);
    check("ovr_flag", overrun, 1);
    check("ovr_byte_held", byte_out, 8'h11);
    check("ovr_valid_held", byte_valid, 1);
    pulse(P_START);
    check("ovr_cleared_by_start", overrun, 0);
    check("ovr_valid_after_start", byte_valid, 1);
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
    check("ovr_drained", byte_valid, 0);

    // Capture coincides with the consumer draining the previous byte: new byte is held.
    idle(1);
    send_byte(8'hE2, 1'b0, a, b, c, re);
    check("hold_addr_ack", a, 1);
    exp_q.push_back(8'h44);
    send_byte(8'h44, 1'b0, a, b, c, re);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, a, b, c, re);
    check("hold_ack", a, 1);
    check("hold_valid", byte_valid, 1);
    check("hold_byte_out", byte_out, 8'h55);
    check("hold_no_overrun", overrun, 0);
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
    pulse(P_STOP);

    // STOP after four data bits: partial byte discarded.
    byte_ready = 1'b1;
    idle(2);
    pulse(P_START); idle(2);
    send_byte(8'hE2, 1'b0, a, b, c, re);
    rx_data = 8'hF0;
    send_bits(4);
    pulse(P_STOP);
    check("stop_mid_busy", busy, 0);
    check("stop_mid_valid", byte_valid, 0);
    check("stop_mid_sda", sda_drive_low, 0);
    check("stop_mid_rx_enable", rx_enable, 0);

    // Repeated START mid-data, then a fresh address must align on eight bits.
    idle(2);
    pulse(P_START); idle(2);
    send_byte(8'hE2, 1'b0, a, b, c, re);
    send_bits(3);
    pulse(P_START);
    check("rs_busy", busy, 1);
    check("rs_rx_enable", rx_enable, 1);
    check("rs_matched_cleared", addr_matched, 0);
    idle(2);
    send_byte(8'hE2, 1'b0, a, b, c, re);
    check("rs_addr_ack", a, 1);
    check("rs_addr_ack_9th", b, 1);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b0, a, b, c, re);
    check("rs_data_ack", a, 1);

    // STOP and START together: STOP wins.
    start_found = 1'b1; stop_found = 1'b1;
    tick();
    start_found = 1'b0; stop_found = 1'b0;
    check("stop_wins_busy", busy, 0);
    check("stop_wins_rx_enable", rx_enable, 0);

    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
